// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter
// Round-robin N:1 arbiter that merges several requesters onto one
// single-port SRAM macro (A/D/CEN/WEN) with registered SRAM-side outputs.
// Read data is steered back to the issuing port by a latency-tracking
// pipeline.
// Optional build macro: SRAM_ARB_LOCK_EN adds a per-port 'lock' input.
// When it is set, the port that holds the lock keeps priority across
// consecutive transfers.
// ADDR_WIDTH / DATA_WIDTH default to 10 / 16 when the surrounding build
// does not define them.

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 10
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif

module sram_port_arbiter #(
   parameter int NUM_PORTS = 4,
   parameter int ADDR_W    = `ADDR_WIDTH,
   parameter int DATA_W    = `DATA_WIDTH,
   parameter int RD_LAT    = 1
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_PORTS-1:0]          req,
   input  logic [NUM_PORTS-1:0]          we,
   input  logic [NUM_PORTS*ADDR_W-1:0]   addr,
   input  logic [NUM_PORTS*DATA_W-1:0]   wdata,
   output logic [NUM_PORTS-1:0]          gnt,
   output logic [NUM_PORTS-1:0]          rvalid,
   output logic [DATA_W-1:0]             rdata,
   output logic [ADDR_W-1:0]             A_out,
   output logic [DATA_W-1:0]             D_out,
   output logic                          CEN_out,
   output logic                          WEN_out,
`ifdef SRAM_ARB_LOCK_EN
   input  logic [NUM_PORTS-1:0]          lock,
`endif
   input  logic [DATA_W-1:0]             Q_in
);

   localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

   typedef logic [IDX_W-1:0] idx_t;

   idx_t                rr_ptr;
   idx_t                next_ptr;
   idx_t                win_idx;
   idx_t                ptr_inc;
   logic                found;
   logic                xfer;
   logic                sel_we;
   logic [ADDR_W-1:0]   sel_addr;
   logic [DATA_W-1:0]   sel_wdata;

   logic                cmd_rd;
   idx_t                cmd_port;
   logic [RD_LAT-1:0]   rd_vld;
   idx_t                rd_port [RD_LAT];

   // Find the first requester at or above the pointer; if none, wrap to the lowest requester
   always_comb begin
      logic found_hi;
      logic found_lo;
      idx_t hi_idx;
      idx_t lo_idx;
      found_hi = 1'b0;
      found_lo = 1'b0;
      hi_idx   = '0;
      lo_idx   = '0;
      for (int i = NUM_PORTS - 1; i >= 0; i--) begin
         if (req[i] && (i >= int'(rr_ptr))) begin
            hi_idx   = idx_t'(i);
            found_hi = 1'b1;
         end
         if (req[i]) begin
            lo_idx   = idx_t'(i);
            found_lo = 1'b1;
         end
      end
      found   = found_hi | found_lo;
      win_idx = found_hi ? hi_idx : lo_idx;
   end

   // Grant is a one-hot decode of the winner, forced off while reset is held
   always_comb begin
      gnt  = '0;
      xfer = found & rst_n;
      for (int i = 0; i < NUM_PORTS; i++) begin
         gnt[i] = xfer && (win_idx == idx_t'(i));
      end
   end

   // Select the winning port's command fields
   always_comb begin
      sel_we    = 1'b0;
      sel_addr  = '0;
      sel_wdata = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (win_idx == idx_t'(i)) begin
            sel_we    = we[i];
            sel_addr  = addr[i*ADDR_W +: ADDR_W];
            sel_wdata = wdata[i*DATA_W +: DATA_W];
         end
      end
   end

   // Pointer value that follows the winner, wrapping at the last port
   always_comb begin
      if (win_idx == idx_t'(NUM_PORTS - 1)) begin
         ptr_inc = '0;
      end else begin
         ptr_inc = win_idx + 1'b1;
      end
   end

`ifdef SRAM_ARB_LOCK_EN
   logic lock_active;
   logic next_lock_active;
   idx_t lock_port;
   idx_t next_lock_port;
   idx_t lock_inc;
   logic sel_lock;
   logic lock_req;

   // Look up the winner's lock bit and whether the locked port is still requesting
   always_comb begin
      sel_lock = 1'b0;
      lock_req = 1'b0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (win_idx == idx_t'(i)) begin
            sel_lock = lock[i];
         end
         if (lock_port == idx_t'(i)) begin
            lock_req = req[i];
         end
      end
      if (lock_port == idx_t'(NUM_PORTS - 1)) begin
         lock_inc = '0;
      end else begin
         lock_inc = lock_port + 1'b1;
      end
   end

   // A locked transfer parks the pointer on the winner; dropping req releases it past that port
   always_comb begin
      next_ptr         = rr_ptr;
      next_lock_active = lock_active;
      next_lock_port   = lock_port;
      if (xfer && sel_lock) begin
         next_ptr         = win_idx;
         next_lock_active = 1'b1;
         next_lock_port   = win_idx;
      end else if (lock_active && !lock_req) begin
         next_ptr         = lock_inc;
         next_lock_active = 1'b0;
      end else if (xfer) begin
         next_ptr         = ptr_inc;
         next_lock_active = 1'b0;
      end
   end

   // Lock bookkeeping register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lock_active <= 1'b0;
         lock_port   <= '0;
      end else begin
         lock_active <= next_lock_active;
         lock_port   <= next_lock_port;
      end
   end
`else
   // Plain round-robin: advance past the winner on every transfer
   always_comb begin
      next_ptr = xfer ? ptr_inc : rr_ptr;
   end
`endif

   // Round-robin pointer register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr <= '0;
      end else begin
         rr_ptr <= next_ptr;
      end
   end

   // Register the SRAM command; idle cycles deselect the macro but keep A/D stable
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         A_out    <= '0;
         D_out    <= '0;
         CEN_out  <= 1'b1;
         WEN_out  <= 1'b1;
         cmd_rd   <= 1'b0;
         cmd_port <= '0;
      end else if (xfer) begin
         A_out    <= sel_addr;
         D_out    <= sel_wdata;
         CEN_out  <= 1'b0;
         WEN_out  <= ~sel_we;
         cmd_rd   <= ~sel_we;
         cmd_port <= win_idx;
      end else begin
         CEN_out  <= 1'b1;
         WEN_out  <= 1'b1;
         cmd_rd   <= 1'b0;
      end
   end

   // Carry each issued read's {valid, port} alongside the SRAM latency so data returns in order
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_vld <= '0;
         for (int s = 0; s < RD_LAT; s++) begin
            rd_port[s] <= '0;
         end
      end else begin
         rd_vld[0]  <= cmd_rd;
         rd_port[0] <= cmd_port;
         for (int s = 1; s < RD_LAT; s++) begin
            rd_vld[s]  <= rd_vld[s-1];
            rd_port[s] <= rd_port[s-1];
         end
      end
   end

   // Decode the pipeline tail into a one-hot valid; data comes straight from the macro
   always_comb begin
      rvalid = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         rvalid[i] = rd_vld[RD_LAT-1] && (rd_port[RD_LAT-1] == idx_t'(i));
      end
      rdata = Q_in;
   end

endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Parametrised successor to the FFT memory-port 2:1 mux.
- Merges NUM_PORTS requesters onto one single-port SRAM macro interface (A, D, CEN, WEN), with round-robin arbitration and a req/gnt handshake.
- SRAM-side outputs are registered; read data is routed back to the issuing port via a latency-tracking pipeline.
- Sits between the FFT butterfly/reorder engines and each SRAM bank.

Parameters:
- NUM_PORTS, 4: number of requesters; 1..8 supported.
- ADDR_W, `ADDR_WIDTH: SRAM address width.
- DATA_W, `DATA_WIDTH: SRAM data width.
- RD_LAT, 1: SRAM read latency in clocks, from the command edge to Q valid; 1..4.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  NUM_PORTS  per-port access request.
- we  in  NUM_PORTS  per-port write (1) / read (0).
- addr  in  NUM_PORTS*ADDR_W  per-port address; port i occupies [i*ADDR_W +: ADDR_W].
- wdata  in  NUM_PORTS*DATA_W  per-port write data, packed the same way.
- gnt  out  NUM_PORTS  one-hot grant, combinational, same cycle as req.
- rvalid  out  NUM_PORTS  one-hot read-data-valid.
- rdata  out  DATA_W  read data, shared by all ports.
- A_out  out  ADDR_W  SRAM address, registered.
- D_out  out  DATA_W  SRAM write data, registered.
- CEN_out  out  1  SRAM chip enable, active-low, registered.
- WEN_out  out  1  SRAM write enable, active-low, registered.
- Q_in  in  DATA_W  SRAM read data.
- lock  in  NUM_PORTS  grant lock; present only with SRAM_ARB_LOCK_EN.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - A_out=0, D_out=0, CEN_out=1, WEN_out=1.
  - rvalid=0, RR pointer=0, read-tracking pipeline cleared.
  - gnt=0 while rst_n=0.
- Arbitration (combinational):
  - Search req starting at pointer p, upward, wrapping NUM_PORTS-1 -> 0.
  - The first set bit wins; gnt has at most one bit set and is 0 when req=0.
- Handshake:
  - A transfer occurs in the cycle where req[i]&gnt[i]=1.
  - The requester holds addr/we/wdata stable while req[i]=1 and gnt[i]=0.
  - Deasserting req before grant is legal and drops the request.
- Pointer update:
  - On a transfer by port w, p <= (w+1) mod NUM_PORTS at the clock edge.
  - With no transfer, p holds.
- SRAM command (registered, 1 cycle after the transfer cycle):
  - CEN_out<=0, WEN_out<=~we[w], A_out<=addr[w], D_out<=wdata[w].
  - In cycles with no transfer: CEN_out<=1, WEN_out<=1, A_out/D_out hold their previous values.
- Throughput: one access per clock; back-to-back transfers from any ports with no bubble.
- Read return:
  - For a read transfer by port w at edge E (command driven after E), rvalid[w]=1 in the cycle following edge E+RD_LAT.
  - rdata = Q_in, combinational pass-through; rdata is don't-care when rvalid=0.
  - Tracking is an RD_LAT-deep shift register of {valid, port index}, so multiple outstanding reads return in order, one per cycle.
- Writes produce no rvalid.
- Reset mid-operation: outstanding reads are discarded and no rvalid is produced for them.
- NUM_PORTS=1: gnt[0]=req[0] and the pointer is constant 0.

Optional Feature:
- Macro: SRAM_ARB_LOCK_EN.
- Defined:
  - The lock port exists.
  - If port w transfers with lock[w]=1, it retains priority: p is not advanced and the next arbitration starts at w, so w wins again while req[w]=1.
  - Lock ends on the first transfer by w with lock[w]=0 (p then advances normally), or when req[w]=0 in any cycle (p<=(w+1) mod NUM_PORTS).
  - Used for atomic burst read-modify-write sequences.
- Undefined: no lock port; pure round-robin.

Test Plan:
- Reset: assert rst_n=0 mid-stream -> outputs immediately CEN_out=1, WEN_out=1, A_out=0, rvalid=0; after release, first req[2]=1 gets gnt=4'b0100.
- Round-robin: NUM_PORTS=4, req=4'b1111 held for 8 cycles -> gnt sequence 0001,0010,0100,1000,0001,...; CEN_out=0 on every cycle from cycle 2.
- Write path: port 1 writes addr 0x12, data 0xABCD -> next cycle A_out=0x12, D_out=0xABCD, CEN_out=0, WEN_out=0; following idle cycle CEN_out=1, A_out holds 0x12.
- Read return, RD_LAT=2: port 3 reads addr 0x05 then port 0 reads 0x06 back-to-back, SRAM model returns 0x1111/0x2222 -> rvalid=1000 with rdata=0x1111, next cycle rvalid=0001 with rdata=0x2222.
- Starvation/wrap: req=4'b1001 continuous, p=3 -> grants alternate 1000,0001,1000; no port waits more than NUM_PORTS-1 cycles.
- Lock (SRAM_ARB_LOCK_EN): port 2 with lock=1 for 3 transfers while req=1111 -> gnt=0100 x3; then lock=0 -> next two grants 0100,1000.
